// File: rtl/me_blt_ctl_pkg.sv
// Shared game constants and the player FSM encoding.
// The collision controller imports the same package, so both blocks agree on these values.
package me_blt_ctl_pkg;
   localparam int NBLT    = 13;
   localparam int COORD_W = 9;
   localparam int IDX_W   = 4;
   localparam int ME_W    = 35;
   localparam int ME_H    = 35;
   localparam int BLT_W   = 15;
   localparam int BLT_H   = 15;

   typedef enum logic [1:0] {
      ST_ALIVE    = 2'd0,
      ST_COOLDOWN = 2'd1,
      ST_DEAD     = 2'd2
   } me_state_e;

   function automatic logic [IDX_W-1:0] popcount(input logic [NBLT-1:0] v);
      logic [IDX_W-1:0] c;
      c = '0;
      for (int i = 0; i < NBLT; i++) c = c + IDX_W'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/me_blt_ctl_slot_alloc.sv
// Lowest-index free-slot priority encoder for the bullet pool.
module blt_slot_alloc
   import me_blt_ctl_pkg::*;
(
   input  logic [NBLT-1:0]  free,
   output logic [IDX_W-1:0] idx,
   output logic             any_free
);
   always_comb begin
      idx      = '0;
      any_free = |free;
      for (int j = NBLT - 1; j >= 0; j--) begin
         if (free[j]) idx = IDX_W'(j);
      end
   end
endmodule

// File: rtl/me_blt_ctl.sv
// Player bullet pool: spawns on fire, moves bullets up on the game tick,
// retires bullets on elimination or when they leave the top edge, and gates fire rate.
//
//   state       | meaning
//   ST_ALIVE    | firing allowed
//   ST_COOLDOWN | shot just taken, waiting out the cooldown ticks
//   ST_DEAD     | player hit, firing disabled for the dead ticks
module me_blt_ctl
   import me_blt_ctl_pkg::*;
#(
   parameter int STEP_DIV       = 250000,
   parameter int SPEED          = 4,
   parameter int COOLDOWN_TICKS = 8,
   parameter int DEAD_TICKS     = 50,
   parameter int SPAWN_DX       = 10,
   parameter int BLT_H          = me_blt_ctl_pkg::BLT_H
) (
   input  logic                      clk_main,
   input  logic                      rst,
   input  logic                      fire,
   input  logic [COORD_W-1:0]        me_x,
   input  logic [COORD_W-1:0]        me_y,
   input  logic [NBLT-1:0]           eli_me_blt,
   input  logic                      eli_me,
   output logic [NBLT*COORD_W-1:0]   me_blt_x,
   output logic [NBLT*COORD_W-1:0]   me_blt_y,
   output logic [NBLT-1:0]           me_blt_vi,
   output logic                      fire_ack,
   output logic [IDX_W-1:0]          blt_count
);
   localparam int TICK_W  = $clog2(STEP_DIV);
   localparam int TMR_MAX = (COOLDOWN_TICKS > DEAD_TICKS) ? COOLDOWN_TICKS : DEAD_TICKS;
   localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);

   logic [TICK_W-1:0]  tick_cnt;
   logic               tick;
   me_state_e          state, state_nxt;
   logic [TMR_W-1:0]   cd_cnt, cd_nxt, dead_cnt, dead_nxt;
   logic               shot_ok;
   logic [NBLT-1:0]    free;
   logic [IDX_W-1:0]   spawn_idx;
   logic               any_free;
   logic [NBLT-1:0]    vi_nxt;
   logic [COORD_W-1:0] blt_x [NBLT];
   logic [COORD_W-1:0] blt_y [NBLT];
   logic [COORD_W-1:0] x_nxt [NBLT];
   logic [COORD_W-1:0] y_nxt [NBLT];

   assign tick = (tick_cnt == TICK_W'(STEP_DIV - 1));

   always_ff @(posedge clk_main) begin
      if (!rst)      tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // A slot still under an elimination pulse is not free, so it cannot be respawned mid-pulse.
   assign free = ~me_blt_vi & ~eli_me_blt;

   blt_slot_alloc u_alloc (
      .free     (free),
      .idx      (spawn_idx),
      .any_free (any_free)
   );

   always_ff @(posedge clk_main) begin
      if (!rst) begin
         state    <= ST_ALIVE;
         cd_cnt   <= '0;
         dead_cnt <= '0;
      end else begin
         state    <= state_nxt;
         cd_cnt   <= cd_nxt;
         dead_cnt <= dead_nxt;
      end
   end

   // Cooldown idles one tick at zero so held fire repeats every COOLDOWN_TICKS+1 ticks;
   // dead time leaves on the tick that counts it down to zero.
   always_comb begin
      state_nxt = state;
      cd_nxt    = cd_cnt;
      dead_nxt  = dead_cnt;
      if (eli_me) begin
         state_nxt = ST_DEAD;
         dead_nxt  = TMR_W'(DEAD_TICKS);
      end else begin
         case (state)
            ST_ALIVE: begin
               if (shot_ok) begin
                  state_nxt = ST_COOLDOWN;
                  cd_nxt    = TMR_W'(COOLDOWN_TICKS);
               end
            end
            ST_COOLDOWN: begin
               if (tick) begin
                  if (cd_cnt == '0) state_nxt = ST_ALIVE;
                  else              cd_nxt    = cd_cnt - TMR_W'(1);
               end
            end
            ST_DEAD: begin
               if (tick) begin
                  if (dead_cnt <= TMR_W'(1)) begin
                     state_nxt = ST_ALIVE;
                     dead_nxt  = '0;
                  end else begin
                     dead_nxt  = dead_cnt - TMR_W'(1);
                  end
               end
            end
            default: state_nxt = ST_ALIVE;
         endcase
      end
   end

   always_comb begin
      shot_ok = (state == ST_ALIVE) && fire && !eli_me && any_free &&
                (me_y >= COORD_W'(BLT_H));
   end

   always_comb begin
      vi_nxt = me_blt_vi;
      x_nxt  = blt_x;
      y_nxt  = blt_y;
      for (int j = 0; j < NBLT; j++) begin
         if (eli_me_blt[j]) begin
            vi_nxt[j] = 1'b0;
         end else if (tick && me_blt_vi[j]) begin
            if (blt_y[j] < COORD_W'(SPEED)) vi_nxt[j] = 1'b0;
            else                            y_nxt[j]  = blt_y[j] - COORD_W'(SPEED);
         end
         if (shot_ok && (spawn_idx == IDX_W'(j))) begin
            vi_nxt[j] = 1'b1;
            x_nxt[j]  = me_x + COORD_W'(SPAWN_DX);
            y_nxt[j]  = me_y - COORD_W'(BLT_H);
         end
      end
   end

   always_ff @(posedge clk_main) begin
      if (!rst) begin
         me_blt_vi <= '0;
         fire_ack  <= 1'b0;
         blt_count <= '0;
         for (int j = 0; j < NBLT; j++) begin
            blt_x[j] <= '0;
            blt_y[j] <= '0;
         end
      end else begin
         me_blt_vi <= vi_nxt;
         fire_ack  <= shot_ok;
         blt_count <= popcount(vi_nxt);
         blt_x     <= x_nxt;
         blt_y     <= y_nxt;
      end
   end

   for (genvar g = 0; g < NBLT; g++) begin : g_pack
      assign me_blt_x[g*COORD_W +: COORD_W] = blt_x[g];
      assign me_blt_y[g*COORD_W +: COORD_W] = blt_y[g];
   end
endmodule

// File: tb/tb_me_blt_ctl.sv
// Scoreboard bench for me_blt_ctl: directed stimulus queues expected spawns,
// a forked monitor checks each fire_ack against the queue.
module tb_me_blt_ctl;
   import me_blt_ctl_pkg::*;

   logic                    clk_main = 1'b0;
   logic                    rst;
   logic                    fire;
   logic [COORD_W-1:0]      me_x, me_y;
   logic [NBLT-1:0]         eli_me_blt;
   logic                    eli_me;
   logic [NBLT*COORD_W-1:0] me_blt_x, me_blt_y;
   logic [NBLT-1:0]         me_blt_vi;
   logic                    fire_ack;
   logic [IDX_W-1:0]        blt_count;

   always #5 clk_main = ~clk_main;

   me_blt_ctl #(
      .STEP_DIV(4), .SPEED(4), .COOLDOWN_TICKS(2), .DEAD_TICKS(3)
   ) dut (
      .clk_main   (clk_main),
      .rst        (rst),
      .fire       (fire),
      .me_x       (me_x),
      .me_y       (me_y),
      .eli_me_blt (eli_me_blt),
      .eli_me     (eli_me),
      .me_blt_x   (me_blt_x),
      .me_blt_y   (me_blt_y),
      .me_blt_vi  (me_blt_vi),
      .fire_ack   (fire_ack),
      .blt_count  (blt_count)
   );

   typedef struct {
      int cyc;
      int slot;
      int x;
      int y;
      int vi;
      int cnt;
   } exp_t;

   exp_t sb_q[$];
   int   cyc;
   int   checks = 0;
   int   errors = 0;

   // Edges since reset release; tick effects land on edges where cyc % 4 == 0.
   always @(posedge clk_main) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic logic [COORD_W-1:0] slot_x(input int j);
      return me_blt_x[j*COORD_W +: COORD_W];
   endfunction

   function automatic logic [COORD_W-1:0] slot_y(input int j);
      return me_blt_y[j*COORD_W +: COORD_W];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_main);
      #1;
   endtask

   task automatic go_to(input int k);
      while (cyc < k) step(1);
   endtask

   task automatic push(input int c, input int s, input int x, input int y, input int vi, input int cnt);
      exp_t e;
      e.cyc = c; e.slot = s; e.x = x; e.y = y; e.vi = vi; e.cnt = cnt;
      sb_q.push_back(e);
   endtask

   task automatic drain(input string name);
      chk(name, sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vi"},    32'(me_blt_vi), 0);
      chk({tag, "_x_or"},  32'(|me_blt_x), 0);
      chk({tag, "_y_or"},  32'(|me_blt_y), 0);
      chk({tag, "_ack"},   32'(fire_ack), 0);
      chk({tag, "_count"}, 32'(blt_count), 0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0; fire = 1'b0; eli_me = 1'b0; eli_me_blt = '0; me_x = '0; me_y = '0;
      step(2);
      chk_zero(tag);
      rst = 1'b1;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(posedge clk_main);
         #1;
         if (fire_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack act=1 exp=0 (cyc %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               chk("ack_cycle", cyc, e.cyc);
               chk("ack_vi", 32'(me_blt_vi), e.vi);
               chk("ack_x", 32'(slot_x(e.slot)), e.x);
               chk("ack_y", 32'(slot_y(e.slot)), e.y);
               chk("ack_count", 32'(blt_count), e.cnt);
            end
         end
      end
   endtask

   initial begin
      int mask;
      int slot;
      fork
         monitor();
      join_none

      // 1: single shot, then one tick of motion
      do_reset("t1_rst");
      push(1, 0, 110, 185, 'h001, 1);
      fire = 1'b1; me_x = 9'd100; me_y = 9'd200;
      go_to(1);
      fire = 1'b0;
      go_to(4);
      chk("t1_move_y", 32'(slot_y(0)), 181);
      chk("t1_vi", 32'(me_blt_vi), 'h001);
      drain("t1_drain");

      // 2: held fire fills all 13 slots, one shot every 3 ticks
      do_reset("t2_rst");
      for (int n = 0; n < NBLT; n++) push(1 + 12*n, n, 110, 185, (1 << (n + 1)) - 1, n + 1);
      fire = 1'b1; me_x = 9'd100; me_y = 9'd200;
      go_to(186);
      chk("t2_full_count", 32'(blt_count), 13);
      chk("t2_full_vi", 32'(me_blt_vi), 'h1fff);
      fire = 1'b0;
      drain("t2_drain");

      // 3: off-screen retirement at y=3 and y=4
      do_reset("t3_rst");
      push(1, 0, 110, 3, 'h001, 1);
      fire = 1'b1; me_x = 9'd100; me_y = 9'd18;
      go_to(1);
      fire = 1'b0;
      go_to(3);
      chk("t3_y3_alive", 32'(me_blt_vi), 'h001);
      chk("t3_y3_pos", 32'(slot_y(0)), 3);
      go_to(4);
      chk("t3_y3_gone", 32'(me_blt_vi), 0);
      chk("t3_y3_count", 32'(blt_count), 0);
      go_to(12);
      push(13, 0, 110, 4, 'h001, 1);
      fire = 1'b1; me_y = 9'd19;
      go_to(13);
      fire = 1'b0;
      go_to(16);
      chk("t3_y4_to0", 32'(slot_y(0)), 0);
      chk("t3_y4_alive", 32'(me_blt_vi), 'h001);
      go_to(20);
      chk("t3_y0_gone", 32'(me_blt_vi), 0);
      chk("t3_y0_count", 32'(blt_count), 0);
      drain("t3_drain");

      // 4: long elimination pulse blocks slot 2 until it drops
      do_reset("t4_rst");
      push(1, 0, 110, 185, 'h001, 1);
      push(13, 1, 110, 185, 'h003, 2);
      push(25, 2, 110, 185, 'h007, 3);
      fire = 1'b1; me_x = 9'd100; me_y = 9'd200;
      go_to(25);
      fire = 1'b0;
      go_to(26);
      eli_me_blt = 13'h0002;
      go_to(27);
      eli_me_blt = '0;
      chk("t4_setup_vi", 32'(me_blt_vi), 'h005);
      chk("t4_setup_count", 32'(blt_count), 2);
      go_to(36);
      mask = 'h001;
      for (int n = 0; n < 10; n++) begin
         slot = (n == 0) ? 1 : ((n == 9) ? 2 : n + 2);
         mask = mask | (1 << slot);
         push(37 + 12*n, slot, 110, 185, mask, n + 2);
      end
      eli_me_blt = 13'h0004; fire = 1'b1;
      go_to(100);
      chk("t4_slot2_blocked", 32'(me_blt_vi[2]), 0);
      go_to(136);
      eli_me_blt = '0;
      go_to(145);
      fire = 1'b0;
      go_to(146);
      drain("t4_drain");

      // 5: eli_me beats a same-cycle shot; 3 dead ticks, bullets keep moving
      do_reset("t5_rst");
      push(1, 0, 110, 185, 'h001, 1);
      push(25, 1, 110, 185, 'h003, 2);
      fire = 1'b1; me_x = 9'd100; me_y = 9'd200;
      go_to(1);
      fire = 1'b0;
      go_to(12);
      fire = 1'b1; eli_me = 1'b1;
      go_to(13);
      eli_me = 1'b0;
      chk("t5_no_spawn_vi", 32'(me_blt_vi), 'h001);
      go_to(20);
      chk("t5_dead_move_y", 32'(slot_y(0)), 165);
      go_to(25);
      fire = 1'b0;
      go_to(26);
      drain("t5_drain");

      // 6: low ship rejected without cooldown, x wraps, reset mid-flight
      do_reset("t6_rst");
      fire = 1'b1; me_x = 9'd100; me_y = 9'd10;
      go_to(1);
      chk("t6_reject_vi", 32'(me_blt_vi), 0);
      chk("t6_reject_ack", 32'(fire_ack), 0);
      push(2, 0, 3, 0, 'h001, 1);
      me_x = 9'd505; me_y = 9'd15;
      go_to(2);
      fire = 1'b0;
      go_to(3);
      rst = 1'b0;
      step(1);
      chk_zero("t6_midflight");
      rst = 1'b1;
      drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
